hessian_scale_sched: RTL and testbench

- Round-robin scheduler that time-shares one hessian_32f datapath between NUM_REQ scale-layer requesters.
- Per cycle, grants at most one requester. The external box-sum mux is driven from sel; the grant is pulsed as the datapath din_valid.
- A scale tag travels through a PIPE_LAT-deep delay line so every determinant leaving the datapath is labelled with its scale.
- Counts issued and returned determinants per scale and signals frame completion.

---
 rtl/hessian_scale_sched.sv | 271 +++++++++++++++++++++++++++
 tb/tb_hessian_scale_sched.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hessian_scale_sched.sv
// hessian_scale_sched: round-robin scheduler that time-shares one hessian_32f
// datapath between NUM_REQ scale-layer requesters, tags every issued request
// with its scale through a PIPE_LAT-deep delay line, and counts issued and
// returned determinants per scale to detect frame completion.
//
// Optional feature macro: HESS_SCHED_THRESH_EN
//   Adds input thresh and output cand_cnt; only determinants strictly above
//   thresh (signed) are forwarded on det_valid. Without the macro every
//   datapath output is forwarded and neither port exists.
//
// state | meaning
// IDLE  | waiting for start, no grants
// RUN   | arbitrating requesters and issuing box sums to the datapath
// DRAIN | every scale fully issued, waiting for the remaining determinants
// DONE  | frame complete, done pulses for one cycle
`timescale 1ns/1ps

module hessian_scale_sched #(
    parameter int NUM_REQ       = 4,
    parameter int SEL_W         = 2,
    parameter int PIPE_LAT      = 9,
    parameter int DET_W         = 32,
    parameter int CNT_W         = 20,
    parameter int PIX_PER_SCALE = 307200
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   sel,
    output logic               hs_din_valid,
    input  logic               hs_o_d_valid,
    input  logic [DET_W-1:0]   hs_o_d,
`ifdef HESS_SCHED_THRESH_EN
    input  logic [DET_W-1:0]   thresh,
    output logic [CNT_W-1:0]   cand_cnt,
`endif
    output logic               det_valid,
    output logic [DET_W-1:0]   det_data,
    output logic [SEL_W-1:0]   det_scale,
    output logic               busy,
    output logic               done,
    output logic               err_sync
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] PPS_C     = CNT_W'(PIX_PER_SCALE);
    localparam logic [SEL_W-1:0] RR_INIT_C = SEL_W'(NUM_REQ - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   issue_cnt_q [NUM_REQ];
    logic [CNT_W-1:0]   issue_cnt_d [NUM_REQ];
    logic [CNT_W-1:0]   ret_cnt_q   [NUM_REQ];
    logic [CNT_W-1:0]   ret_cnt_d   [NUM_REQ];
    logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic [PIPE_LAT-1:0] tag_v_q;
    logic [SEL_W-1:0]    tag_s_q [PIPE_LAT];
    logic                tail_v;
    logic [SEL_W-1:0]    tail_s;

    logic               det_valid_q, det_valid_d;
    logic [DET_W-1:0]   det_data_q;
    logic [SEL_W-1:0]   det_scale_q;
    logic               err_q, err_d;

    logic               start_acc;
    logic               all_issued;
    logic               all_returned;
    logic [NUM_REQ-1:0] eligible;
    logic               gnt_found;
    logic [SEL_W-1:0]   gnt_idx;
    logic [SEL_W-1:0]   arb_idx;

    assign start_acc = start && (state_q == S_IDLE);
    assign tail_v    = tag_v_q[PIPE_LAT-1];
    assign tail_s    = tag_s_q[PIPE_LAT-1];

    // Per-scale completion flags and request eligibility (saturated counters drop out).
    always_comb begin
        all_issued   = 1'b1;
        all_returned = 1'b1;
        eligible     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (issue_cnt_q[i] < PPS_C) begin
                all_issued  = 1'b0;
                eligible[i] = req[i];
            end
            if (ret_cnt_q[i] < PPS_C) begin
                all_returned = 1'b0;
            end
        end
    end

    // Round-robin search starting just above the last granted index, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        arb_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            arb_idx = SEL_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!gnt_found && eligible[arb_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = arb_idx;
            end
        end
    end

    // Grant, mux select and datapath valid; only RUN may issue.
    always_comb begin
        gnt          = '0;
        sel          = '0;
        hs_din_valid = 1'b0;
        if ((state_q == S_RUN) && gnt_found) begin
            gnt[gnt_idx] = 1'b1;
            sel          = gnt_idx;
            hs_din_valid = 1'b1;
        end
    end

    // Next-state logic for the frame sequencer.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start)        state_d = S_RUN;
            S_RUN:   if (all_issued)   state_d = S_DRAIN;
            S_DRAIN: if (all_returned) state_d = S_DONE;
            S_DONE:                    state_d = S_IDLE;
            default:                   state_d = S_IDLE;
        endcase
    end

    // Round-robin pointer follows the most recent grant; it is not reset by start.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (hs_din_valid) begin
            rr_ptr_d = sel;
        end
    end

    // Issue/return counters: cleared on an accepted start, saturating otherwise.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            issue_cnt_d[i] = issue_cnt_q[i];
            ret_cnt_d[i]   = ret_cnt_q[i];
        end
        if (start_acc) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                issue_cnt_d[i] = '0;
                ret_cnt_d[i]   = '0;
            end
        end else begin
            if (hs_din_valid && (issue_cnt_q[sel] < PPS_C)) begin
                issue_cnt_d[sel] = issue_cnt_q[sel] + CNT_W'(1);
            end
            if (hs_o_d_valid && (ret_cnt_q[tail_s] < PPS_C)) begin
                ret_cnt_d[tail_s] = ret_cnt_q[tail_s] + CNT_W'(1);
            end
        end
    end

    // Sync error: datapath valid disagrees with the tag pipe, or output while idle.
    always_comb begin
        err_d = err_q;
        if (start_acc) begin
            err_d = 1'b0;
        end
        if ((hs_o_d_valid != tail_v) || (hs_o_d_valid && (state_q == S_IDLE))) begin
            err_d = 1'b1;
        end
    end

`ifdef HESS_SCHED_THRESH_EN
    logic [CNT_W-1:0] cand_cnt_q, cand_cnt_d;

    // Forward only determinants strictly above the signed threshold.
    always_comb begin
        det_valid_d = hs_o_d_valid && ($signed(hs_o_d) > $signed(thresh));
    end

    // Candidate counter: cleared on start, holds at its maximum value.
    always_comb begin
        cand_cnt_d = cand_cnt_q;
        if (start_acc) begin
            cand_cnt_d = '0;
        end else if (det_valid_d && (cand_cnt_q != '1)) begin
            cand_cnt_d = cand_cnt_q + CNT_W'(1);
        end
    end

    // Candidate counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_cnt_q <= '0;
        end else begin
            cand_cnt_q <= cand_cnt_d;
        end
    end

    assign cand_cnt = cand_cnt_q;
`else
    // Every datapath output is forwarded.
    always_comb begin
        det_valid_d = hs_o_d_valid;
    end
`endif

    // Sequencer state, pointer, counters and sync flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= RR_INIT_C;
            err_q    <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                issue_cnt_q[i] <= '0;
                ret_cnt_q[i]   <= '0;
            end
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            err_q       <= err_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
        end
    end

    // Scale tag delay line, aligned with the datapath latency; shifts every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v_q <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                tag_s_q[i] <= '0;
            end
        end else begin
            tag_v_q[0] <= hs_din_valid;
            tag_s_q[0] <= sel;
            for (int i = 1; i < PIPE_LAT; i++) begin
                tag_v_q[i] <= tag_v_q[i-1];
                tag_s_q[i] <= tag_s_q[i-1];
            end
        end
    end

    // Registered output stage: determinant labelled with its tail scale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            det_valid_q <= 1'b0;
            det_data_q  <= '0;
            det_scale_q <= '0;
        end else begin
            det_valid_q <= det_valid_d;
            det_data_q  <= hs_o_d;
            det_scale_q <= tail_s;
        end
    end

    assign det_valid = det_valid_q;
    assign det_data  = det_data_q;
    assign det_scale = det_scale_q;
    assign err_sync  = err_q;
    assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_hessian_scale_sched.sv
// Directed bench for hessian_scale_sched with PIX_PER_SCALE=3, PIPE_LAT=9.
// The datapath is modelled as a 9-cycle delay of det = {2'b00, scale, seq}.
`timescale 1ns/1ps

module tb_hessian_scale_sched;

    localparam int NUM_REQ  = 4;
    localparam int SEL_W    = 2;
    localparam int PIPE_LAT = 9;
    localparam int DET_W    = 32;
    localparam int CNT_W    = 20;
    localparam int PPS      = 3;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [NUM_REQ-1:0] req = '0;
    logic [NUM_REQ-1:0] gnt;
    logic [SEL_W-1:0]   sel;
    logic               hs_din_valid;
    logic               hs_o_d_valid;
    logic [DET_W-1:0]   hs_o_d;
    logic               det_valid;
    logic [DET_W-1:0]   det_data;
    logic [SEL_W-1:0]   det_scale;
    logic               busy;
    logic               done;
    logic               err_sync;
`ifdef HESS_SCHED_THRESH_EN
    logic [DET_W-1:0]   thresh = '0;
    logic [CNT_W-1:0]   cand_cnt;
`endif

    logic               inj_v = 1'b0;
    logic [DET_W-1:0]   inj_d = '0;
    logic [PIPE_LAT-1:0] mv;
    logic [DET_W-1:0]   md [PIPE_LAT];
    logic [27:0]        seq;

    int checks = 0;
    int errors = 0;

    hessian_scale_sched #(
        .NUM_REQ(NUM_REQ), .SEL_W(SEL_W), .PIPE_LAT(PIPE_LAT),
        .DET_W(DET_W), .CNT_W(CNT_W), .PIX_PER_SCALE(PPS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .req(req),
        .gnt(gnt),
        .sel(sel),
        .hs_din_valid(hs_din_valid),
        .hs_o_d_valid(hs_o_d_valid),
        .hs_o_d(hs_o_d),
`ifdef HESS_SCHED_THRESH_EN
        .thresh(thresh),
        .cand_cnt(cand_cnt),
`endif
        .det_valid(det_valid),
        .det_data(det_data),
        .det_scale(det_scale),
        .busy(busy),
        .done(done),
        .err_sync(err_sync)
    );

    always #5 clk = ~clk;

    // Datapath model: fixed 9-cycle latency, det encodes scale and issue order.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mv  <= '0;
            seq <= '0;
            for (int i = 0; i < PIPE_LAT; i++) md[i] <= '0;
        end else begin
            mv    <= {mv[PIPE_LAT-2:0], hs_din_valid};
            md[0] <= hs_din_valid ? {2'b00, sel, seq} : '0;
            for (int i = 1; i < PIPE_LAT; i++) md[i] <= md[i-1];
            if (hs_din_valid) seq <= seq + 28'd1;
        end
    end

    assign hs_o_d_valid = mv[PIPE_LAT-1] | inj_v;
    assign hs_o_d       = inj_v ? inj_d : md[PIPE_LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Settle after driving, then confirm any delivered determinant carries its own scale.
    task automatic look();
        #1;
        if (det_valid) chk("tag_scale", 32'(det_scale), 32'(det_data[29:28]));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_g;
        logic [3:0] fill_seq [3];
        fill_seq[0] = 4'b1000;
        fill_seq[1] = 4'b0001;
        fill_seq[2] = 4'b0010;

        // Reset state
        #3;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_din_valid", 32'(hs_din_valid), 32'd0);
        chk("rst_det_valid", 32'(det_valid), 32'd0);
        chk("rst_det_data", det_data, 32'd0);
        chk("rst_det_scale", 32'(det_scale), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err_sync), 32'd0);
        step(); step();
        rst_n = 1'b1;

        // Fair arbitration: all requesters, 3 rounds of 0001,0010,0100,1000
        step(); start = 1'b1; req = 4'b1111; look();
        chk("idle_gnt", 32'(gnt), 32'd0);
        for (int c = 0; c < 24; c++) begin
            step();
            if (c == 0) start = 1'b0;
            look();
            exp_g = (c < 12) ? (4'b0001 << (c % 4)) : 4'b0000;
            chk("fair_gnt", 32'(gnt), 32'(exp_g));
            chk("fair_sel", 32'(sel), (c < 12) ? 32'(c % 4) : 32'd0);
            chk("fair_din_valid", 32'(hs_din_valid), 32'(c < 12));
            chk("fair_busy", 32'(busy), 32'(c <= 21));
            chk("fair_done", 32'(done), 32'(c == 22));
            chk("fair_det_valid", 32'(det_valid), 32'(c >= 10 && c <= 21));
            if (c >= 10 && c <= 21) begin
                chk("fair_det_scale", 32'(det_scale), 32'((c - 10) % 4));
                chk("fair_det_seq", 32'(det_data[27:0]), 32'(c - 10));
            end
            chk("fair_err", 32'(err_sync), 32'd0);
        end

        // Single requester; a start while busy must not clear the counters
        step(); start = 1'b1; req = 4'b0100; look();
        chk("single_idle_gnt", 32'(gnt), 32'd0);
        for (int s = 0; s < 15; s++) begin
            step();
            if (s == 0) start = 1'b0;
            if (s == 4) start = 1'b1;
            if (s == 5) start = 1'b0;
            look();
            chk("single_gnt", 32'(gnt), (s < 3) ? 32'h4 : 32'h0);
            chk("single_busy", 32'(busy), 32'd1);
            chk("single_done", 32'(done), 32'd0);
            if (det_valid) chk("single_det_scale", 32'(det_scale), 32'd2);
            chk("single_err", 32'(err_sync), 32'd0);
        end
        for (int k = 0; k < 9; k++) begin
            step();
            if (k == 0) req = 4'b1111;
            look();
            chk("fill_gnt", 32'(gnt), 32'(fill_seq[k % 3]));
        end
        for (int d = 1; d <= 11; d++) begin
            step(); look();
            chk("fill_gnt_off", 32'(gnt), 32'd0);
            chk("fill_busy", 32'(busy), 32'(d <= 10));
            chk("fill_done", 32'(done), 32'(d == 11));
            chk("fill_err", 32'(err_sync), 32'd0);
        end

        // Sync fault: datapath valid with no prior grant, in IDLE
        step(); inj_v = 1'b1; inj_d = '0; req = 4'b0000; look();
        chk("sync_err_before", 32'(err_sync), 32'd0);
        step(); inj_v = 1'b0; look();
        chk("sync_err_set", 32'(err_sync), 32'd1);
        chk("sync_forwarded", 32'(det_valid), 32'd1);
        for (int h = 0; h < 3; h++) begin
            step(); look();
            chk("sync_err_hold", 32'(err_sync), 32'd1);
        end
        step(); start = 1'b1; look();
        chk("sync_err_pre_start", 32'(err_sync), 32'd1);
        step(); start = 1'b0; look();
        chk("sync_err_clr", 32'(err_sync), 32'd0);
        chk("sync_busy", 32'(busy), 32'd1);

        // Async reset in the middle of RUN (pointer left at scale 1)
        for (int k = 0; k < 12; k++) begin
            step();
            if (k == 0) req = 4'b1111;
            look();
            chk("abort_gnt", 32'(gnt), 32'(4'b0001 << ((2 + k) % 4)));
        end
        chk("abort_det_valid_pre", 32'(det_valid), 32'd1);
        chk("abort_busy_pre", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_gnt_rst", 32'(gnt), 32'd0);
        chk("abort_din_valid_rst", 32'(hs_din_valid), 32'd0);
        chk("abort_busy_rst", 32'(busy), 32'd0);
        chk("abort_det_valid_rst", 32'(det_valid), 32'd0);
        step(); rst_n = 1'b1;
        for (int w = 0; w < 15; w++) begin
            step(); look();
            chk("abort_done", 32'(done), 32'd0);
            chk("abort_det_valid", 32'(det_valid), 32'd0);
            chk("abort_gnt_idle", 32'(gnt), 32'd0);
            chk("abort_busy", 32'(busy), 32'd0);
        end

`ifdef HESS_SCHED_THRESH_EN
        // Threshold filter: only 101 exceeds 100
        req = 4'b0000;
        step(); start = 1'b1; thresh = 32'd100; look();
        step(); start = 1'b0; inj_v = 1'b1; inj_d = 32'd50; look();
        step(); inj_d = 32'd100; look();
        chk("thr_50", 32'(det_valid), 32'd0);
        step(); inj_d = 32'd101; look();
        chk("thr_100", 32'(det_valid), 32'd0);
        step(); inj_d = 32'hFFFF_FFFB; look();
        chk("thr_101", 32'(det_valid), 32'd1);
        chk("thr_101_data", det_data, 32'd101);
        step(); inj_v = 1'b0; look();
        chk("thr_neg5", 32'(det_valid), 32'd0);
        chk("thr_cand_cnt", 32'(cand_cnt), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
